// File: rtl/bpu_pkg.sv
// Shared types and helpers for the gshare branch predictor: 2-bit counter
// encoding and its saturating update.
package bpu_pkg;

  typedef logic [1:0] ctr2_t;

  localparam ctr2_t CTR_SNT = 2'b00;
  localparam ctr2_t CTR_WNT = 2'b01;
  localparam ctr2_t CTR_WT  = 2'b10;
  localparam ctr2_t CTR_ST  = 2'b11;

  function automatic ctr2_t sat_ctr_next(ctr2_t ctr, logic taken);
    if (taken) return (ctr == CTR_ST) ? CTR_ST : ctr + 2'd1;
    else       return (ctr == CTR_SNT) ? CTR_SNT : ctr - 2'd1;
  endfunction

endpackage

// File: rtl/bpu_gshare_dual_btb.sv
// Tagged branch target buffer: one combinational read port, two write ports.
// When both ports write the same entry, port 2 (younger branch) wins.
module bpu_btb #(
  parameter int PC_W  = 9,
  parameter int IDX_W = 6,
  parameter int TAG_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IDX_W-1:0] rd_idx,
  input  logic [TAG_W-1:0] rd_tag,
  output logic             rd_hit,
  output logic [PC_W-1:0]  rd_target,
  input  logic             wr1_en,
  input  logic [IDX_W-1:0] wr1_idx,
  input  logic [TAG_W-1:0] wr1_tag,
  input  logic [PC_W-1:0]  wr1_target,
  input  logic             wr2_en,
  input  logic [IDX_W-1:0] wr2_idx,
  input  logic [TAG_W-1:0] wr2_tag,
  input  logic [PC_W-1:0]  wr2_target
);

  localparam int DEPTH = 1 << IDX_W;

  logic             valid_q  [DEPTH];
  logic [TAG_W-1:0] tag_q    [DEPTH];
  logic [PC_W-1:0]  target_q [DEPTH];

  // Port 2 is written last so its nonblocking update overrides port 1.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
      end
    end else begin
      if (wr1_en) begin
        valid_q[wr1_idx]  <= 1'b1;
        tag_q[wr1_idx]    <= wr1_tag;
        target_q[wr1_idx] <= wr1_target;
      end
      if (wr2_en) begin
        valid_q[wr2_idx]  <= 1'b1;
        tag_q[wr2_idx]    <= wr2_tag;
        target_q[wr2_idx] <= wr2_target;
      end
    end
  end

  assign rd_hit    = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
  assign rd_target = target_q[rd_idx];

endmodule

// File: rtl/bpu_gshare_dual.sv
// Dual-update gshare/bimodal branch predictor with tagged BTB, speculative
// global history with mispredict recovery, and a saturating mispredict count.
module bpu_gshare_dual
  import bpu_pkg::*;
#(
  parameter int PC_W   = 9,
  parameter int IDX_W  = 6,
  parameter int GHR_W  = 6,
  parameter int TAG_W  = 3,
  parameter int GSHARE = 1,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             fetch_valid,
  input  logic [PC_W-1:0]  fetch_pc,
  output logic             pred_taken,
  output logic [PC_W-1:0]  pred_target,
  output logic [GHR_W-1:0] pred_ghr,
  input  logic             upd1_valid,
  input  logic [PC_W-1:0]  upd1_pc,
  input  logic             upd1_taken,
  input  logic [PC_W-1:0]  upd1_target,
  input  logic [GHR_W-1:0] upd1_ghr,
  input  logic             upd1_mispredict,
  input  logic             upd2_valid,
  input  logic [PC_W-1:0]  upd2_pc,
  input  logic             upd2_taken,
  input  logic [PC_W-1:0]  upd2_target,
  input  logic [GHR_W-1:0] upd2_ghr,
  input  logic             upd2_mispredict,
  output logic [GHR_W-1:0] ghr,
  output logic [CNT_W-1:0] mispredict_count
);

  localparam int DEPTH = 1 << IDX_W;

  // Handshake: fetch_valid and updN_valid qualify their buses for one cycle;
  // there is no ready, every valid beat is consumed on the edge it is seen.

  ctr2_t            bht_q [DEPTH];
  logic [GHR_W-1:0] ghr_q;
  logic [CNT_W-1:0] cnt_q;

  logic             btb_hit;
  logic [PC_W-1:0]  btb_target;
  logic [IDX_W-1:0] fetch_bidx, upd1_bidx, upd2_bidx;
  logic             rec1, rec2;
  logic [1:0]       cnt_inc;
  logic [CNT_W:0]   cnt_sum;

  function automatic logic [IDX_W-1:0] bht_index(logic [PC_W-1:0] pc, logic [GHR_W-1:0] h);
    if (GSHARE != 0) return pc[IDX_W-1:0] ^ IDX_W'(h);
    else             return pc[IDX_W-1:0];
  endfunction

  assign fetch_bidx = bht_index(fetch_pc, ghr_q);
  // Resolve uses the history that travelled with the branch, not the live one.
  assign upd1_bidx  = bht_index(upd1_pc, upd1_ghr);
  assign upd2_bidx  = bht_index(upd2_pc, upd2_ghr);

  bpu_btb #(
    .PC_W  (PC_W),
    .IDX_W (IDX_W),
    .TAG_W (TAG_W)
  ) u_btb (
    .clk        (clk),
    .reset      (reset),
    .rd_idx     (fetch_pc[IDX_W-1:0]),
    .rd_tag     (fetch_pc[IDX_W+TAG_W-1:IDX_W]),
    .rd_hit     (btb_hit),
    .rd_target  (btb_target),
    .wr1_en     (upd1_valid & upd1_taken),
    .wr1_idx    (upd1_pc[IDX_W-1:0]),
    .wr1_tag    (upd1_pc[IDX_W+TAG_W-1:IDX_W]),
    .wr1_target (upd1_target),
    .wr2_en     (upd2_valid & upd2_taken),
    .wr2_idx    (upd2_pc[IDX_W-1:0]),
    .wr2_tag    (upd2_pc[IDX_W+TAG_W-1:IDX_W]),
    .wr2_target (upd2_target)
  );

  assign pred_taken  = btb_hit & bht_q[fetch_bidx][1];
  assign pred_target = pred_taken ? btb_target : fetch_pc + PC_W'(1);
  assign pred_ghr    = ghr_q;
  assign ghr         = ghr_q;

  // Same-index resolves chain slot 1 then slot 2 so the net effect is kept.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) bht_q[i] <= CTR_WNT;
    end else if (upd1_valid && upd2_valid && (upd1_bidx == upd2_bidx)) begin
      bht_q[upd1_bidx] <= sat_ctr_next(sat_ctr_next(bht_q[upd1_bidx], upd1_taken), upd2_taken);
    end else begin
      if (upd1_valid) bht_q[upd1_bidx] <= sat_ctr_next(bht_q[upd1_bidx], upd1_taken);
      if (upd2_valid) bht_q[upd2_bidx] <= sat_ctr_next(bht_q[upd2_bidx], upd2_taken);
    end
  end

  assign rec1 = upd1_valid & upd1_mispredict;
  assign rec2 = upd2_valid & upd2_mispredict;

  // Recovery from the oldest mispredict overrides this cycle's fetch shift.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ghr_q <= '0;
    end else if (rec1) begin
      ghr_q <= {upd1_ghr[GHR_W-2:0], upd1_taken};
    end else if (rec2) begin
      ghr_q <= {upd2_ghr[GHR_W-2:0], upd2_taken};
    end else if (fetch_valid && btb_hit) begin
      ghr_q <= {ghr_q[GHR_W-2:0], pred_taken};
    end
  end

  assign cnt_inc = {1'b0, rec1} + {1'b0, rec2};
  assign cnt_sum = {1'b0, cnt_q} + {{(CNT_W-1){1'b0}}, cnt_inc};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
  end

  assign mispredict_count = cnt_q;

endmodule

// File: tb/tb_bpu_gshare_dual.sv
// Bench for bpu_gshare_dual: a gshare instance (16-bit count) and a bimodal
// instance (2-bit count) share stimulus and are checked against an integer model.
module tb_bpu_gshare_dual;

  localparam int PC_W  = 9;
  localparam int GHR_W = 6;
  localparam int DEPTH = 64;

  logic clk = 1'b0;
  logic reset;
  logic fetch_valid;
  logic [PC_W-1:0] fetch_pc;
  logic upd1_valid, upd1_taken, upd1_mispredict;
  logic [PC_W-1:0] upd1_pc, upd1_target;
  logic [GHR_W-1:0] upd1_ghr;
  logic upd2_valid, upd2_taken, upd2_mispredict;
  logic [PC_W-1:0] upd2_pc, upd2_target;
  logic [GHR_W-1:0] upd2_ghr;

  logic g_pred_taken, b_pred_taken;
  logic [PC_W-1:0] g_pred_target, b_pred_target;
  logic [GHR_W-1:0] g_pred_ghr, b_pred_ghr, g_ghr, b_ghr;
  logic [15:0] g_cnt;
  logic [1:0] b_cnt;

  int vectors = 0;
  int misses = 0;

  // Reference model: instance 0 = gshare, instance 1 = bimodal; BTB is shared.
  int m_bht [2][DEPTH];
  int m_ghr [2];
  int m_cnt [2];
  int m_cnt_max [2] = '{65535, 3};
  bit m_bv [DEPTH];
  int m_btag [DEPTH];
  int m_bt [DEPTH];

  always #5 clk = ~clk;

  bpu_gshare_dual #(.GSHARE(1), .CNT_W(16)) dut_g (
    .clk(clk), .reset(reset), .fetch_valid(fetch_valid), .fetch_pc(fetch_pc),
    .pred_taken(g_pred_taken), .pred_target(g_pred_target), .pred_ghr(g_pred_ghr),
    .upd1_valid(upd1_valid), .upd1_pc(upd1_pc), .upd1_taken(upd1_taken),
    .upd1_target(upd1_target), .upd1_ghr(upd1_ghr), .upd1_mispredict(upd1_mispredict),
    .upd2_valid(upd2_valid), .upd2_pc(upd2_pc), .upd2_taken(upd2_taken),
    .upd2_target(upd2_target), .upd2_ghr(upd2_ghr), .upd2_mispredict(upd2_mispredict),
    .ghr(g_ghr), .mispredict_count(g_cnt)
  );

  bpu_gshare_dual #(.GSHARE(0), .CNT_W(2)) dut_b (
    .clk(clk), .reset(reset), .fetch_valid(fetch_valid), .fetch_pc(fetch_pc),
    .pred_taken(b_pred_taken), .pred_target(b_pred_target), .pred_ghr(b_pred_ghr),
    .upd1_valid(upd1_valid), .upd1_pc(upd1_pc), .upd1_taken(upd1_taken),
    .upd1_target(upd1_target), .upd1_ghr(upd1_ghr), .upd1_mispredict(upd1_mispredict),
    .upd2_valid(upd2_valid), .upd2_pc(upd2_pc), .upd2_taken(upd2_taken),
    .upd2_target(upd2_target), .upd2_ghr(upd2_ghr), .upd2_mispredict(upd2_mispredict),
    .ghr(b_ghr), .mispredict_count(b_cnt)
  );

  function automatic int m_sat(int c, bit t);
    if (t) return (c >= 3) ? 3 : c + 1;
    else   return (c <= 0) ? 0 : c - 1;
  endfunction

  function automatic int m_bidx(int m, int pc, int h);
    return (m == 0) ? ((pc % 64) ^ h) : (pc % 64);
  endfunction

  function automatic bit m_hit(int pc);
    return m_bv[pc % 64] && (m_btag[pc % 64] == (pc / 64) % 8);
  endfunction

  function automatic bit m_taken(int m, int pc);
    return m_hit(pc) && (m_bht[m][m_bidx(m, pc, m_ghr[m])] >= 2);
  endfunction

  function automatic int m_target(int m, int pc);
    return m_taken(m, pc) ? m_bt[pc % 64] : (pc + 1) % 512;
  endfunction

  function automatic logic [37:0] exp_vec(int m);
    int pc = int'(fetch_pc);
    return {m_taken(m, pc), 9'(m_target(m, pc)), 6'(m_ghr[m]), 6'(m_ghr[m]), 16'(m_cnt[m])};
  endfunction

  function automatic logic [37:0] dut_vec(int m);
    return (m == 0) ? {g_pred_taken, g_pred_target, g_pred_ghr, g_ghr, g_cnt}
                    : {b_pred_taken, b_pred_target, b_pred_ghr, b_ghr, 14'd0, b_cnt};
  endfunction

  task automatic model_reset;
    for (int i = 0; i < DEPTH; i++) begin
      m_bht[0][i] = 1; m_bht[1][i] = 1;
      m_bv[i] = 0; m_btag[i] = 0; m_bt[i] = 0;
    end
    for (int m = 0; m < 2; m++) begin
      m_ghr[m] = 0; m_cnt[m] = 0;
    end
  endtask

  task automatic model_update;
    int fpc = int'(fetch_pc);
    int p1 = int'(upd1_pc);
    int p2 = int'(upd2_pc);
    bit r1 = upd1_valid && upd1_mispredict;
    bit r2 = upd2_valid && upd2_mispredict;
    for (int m = 0; m < 2; m++) begin
      bit fh = fetch_valid && m_hit(fpc);
      bit ft = m_taken(m, fpc);
      if (upd1_valid) m_bht[m][m_bidx(m, p1, int'(upd1_ghr))] = m_sat(m_bht[m][m_bidx(m, p1, int'(upd1_ghr))], upd1_taken);
      if (upd2_valid) m_bht[m][m_bidx(m, p2, int'(upd2_ghr))] = m_sat(m_bht[m][m_bidx(m, p2, int'(upd2_ghr))], upd2_taken);
      if (r1)      m_ghr[m] = (int'(upd1_ghr) * 2 + int'(upd1_taken)) % 64;
      else if (r2) m_ghr[m] = (int'(upd2_ghr) * 2 + int'(upd2_taken)) % 64;
      else if (fh) m_ghr[m] = (m_ghr[m] * 2 + int'(ft)) % 64;
      m_cnt[m] = m_cnt[m] + int'(r1) + int'(r2);
      if (m_cnt[m] > m_cnt_max[m]) m_cnt[m] = m_cnt_max[m];
    end
    if (upd1_valid && upd1_taken) begin
      m_bv[p1 % 64] = 1; m_btag[p1 % 64] = (p1 / 64) % 8; m_bt[p1 % 64] = int'(upd1_target);
    end
    if (upd2_valid && upd2_taken) begin
      m_bv[p2 % 64] = 1; m_btag[p2 % 64] = (p2 / 64) % 8; m_bt[p2 % 64] = int'(upd2_target);
    end
  endtask

  always @(posedge clk) if (reset === 1'b1) model_update();

  task automatic clear_inputs;
    fetch_valid = 0; fetch_pc = '0;
    upd1_valid = 0; upd1_pc = '0; upd1_taken = 0; upd1_target = '0; upd1_ghr = '0; upd1_mispredict = 0;
    upd2_valid = 0; upd2_pc = '0; upd2_taken = 0; upd2_target = '0; upd2_ghr = '0; upd2_mispredict = 0;
  endtask

  task automatic set_upd1(input logic [8:0] pc, input logic t, input logic [8:0] tgt,
                          input logic [5:0] h, input logic mp);
    upd1_valid = 1; upd1_pc = pc; upd1_taken = t; upd1_target = tgt; upd1_ghr = h; upd1_mispredict = mp;
  endtask

  task automatic set_upd2(input logic [8:0] pc, input logic t, input logic [8:0] tgt,
                          input logic [5:0] h, input logic mp);
    upd2_valid = 1; upd2_pc = pc; upd2_taken = t; upd2_target = tgt; upd2_ghr = h; upd2_mispredict = mp;
  endtask

  task automatic apply_reset;
    @(negedge clk);
    clear_inputs();
    reset = 0;
    model_reset();
    @(negedge clk);
    reset = 1;
  endtask

  task automatic test_reset;
    apply_reset();
    fetch_pc = 9'h005;
    #2;
    vectors++;
    if (b_pred_taken !== 1'b0 || b_pred_target !== 9'h006) begin
      misses++; $display("FAIL reset_lookup: got taken=%0b target=%h expected taken=0 target=006", b_pred_taken, b_pred_target);
    end
    vectors++;
    if (g_ghr !== 6'd0 || g_cnt !== 16'd0) begin
      misses++; $display("FAIL reset_state: got ghr=%h cnt=%h expected 0/0", g_ghr, g_cnt);
    end
    for (int m = 0; m < 2; m++) begin
      vectors++;
      if (dut_vec(m) !== exp_vec(m)) begin
        misses++; $display("FAIL reset_model inst%0d: got %h expected %h", m, dut_vec(m), exp_vec(m));
      end
    end
  endtask

  task automatic test_train_hit;
    apply_reset();
    set_upd1(9'h005, 1, 9'h020, 6'd0, 0);
    @(negedge clk);
    @(negedge clk);
    clear_inputs();
    fetch_pc = 9'h005;
    #2;
    vectors++;
    if (b_pred_taken !== 1'b1 || b_pred_target !== 9'h020) begin
      misses++; $display("FAIL train_hit: got taken=%0b target=%h expected taken=1 target=020", b_pred_taken, b_pred_target);
    end
    for (int m = 0; m < 2; m++) begin
      vectors++;
      if (dut_vec(m) !== exp_vec(m)) begin
        misses++; $display("FAIL train_model inst%0d: got %h expected %h", m, dut_vec(m), exp_vec(m));
      end
    end
  endtask

  task automatic test_alias;
    fetch_pc = 9'h045;
    #2;
    vectors++;
    if (b_pred_taken !== 1'b0 || b_pred_target !== 9'h046) begin
      misses++; $display("FAIL tag_alias: got taken=%0b target=%h expected taken=0 target=046", b_pred_taken, b_pred_target);
    end
    vectors++;
    if (dut_vec(0) !== exp_vec(0)) begin
      misses++; $display("FAIL alias_model inst0: got %h expected %h", dut_vec(0), exp_vec(0));
    end
  endtask

  task automatic test_dual_same_index;
    apply_reset();
    set_upd1(9'h005, 1, 9'h020, 6'd0, 0);
    set_upd2(9'h005, 1, 9'h030, 6'd0, 0);
    @(negedge clk);
    clear_inputs();
    fetch_pc = 9'h005;
    #2;
    vectors++;
    if (b_pred_taken !== 1'b1 || b_pred_target !== 9'h030) begin
      misses++; $display("FAIL dual_same_index: got taken=%0b target=%h expected taken=1 target=030", b_pred_taken, b_pred_target);
    end
    // Two not-taken steps from 11: still taken after one, not taken after two.
    for (int k = 1; k <= 2; k++) begin
      set_upd1(9'h005, 0, 9'h000, 6'd0, 0);
      @(negedge clk);
      clear_inputs();
      fetch_pc = 9'h005;
      #2;
      vectors++;
      if (b_pred_taken !== (k == 1)) begin
        misses++; $display("FAIL dual_ctr_step%0d: got taken=%0b expected %0b", k, b_pred_taken, (k == 1));
      end
      vectors++;
      if (dut_vec(0) !== exp_vec(0)) begin
        misses++; $display("FAIL dual_model inst0 step%0d: got %h expected %h", k, dut_vec(0), exp_vec(0));
      end
    end
  endtask

  task automatic test_recovery;
    apply_reset();
    set_upd1(9'h005, 1, 9'h020, 6'd0, 0);
    @(negedge clk);
    @(negedge clk);
    clear_inputs();
    set_upd1(9'h010, 1, 9'h033, 6'b010110, 1);
    @(negedge clk);
    clear_inputs();
    #2;
    vectors++;
    if (b_ghr !== 6'b101101 || g_ghr !== 6'b101101) begin
      misses++; $display("FAIL recover_set: got b=%b g=%b expected 101101", b_ghr, g_ghr);
    end
    fetch_valid = 1; fetch_pc = 9'h005;
    set_upd1(9'h011, 0, 9'h000, 6'b000011, 1);
    #2;
    vectors++;
    if (b_pred_taken !== 1'b1) begin
      misses++; $display("FAIL recover_fetch_hit: got taken=%0b expected 1", b_pred_taken);
    end
    @(negedge clk);
    clear_inputs();
    #2;
    vectors++;
    if (b_ghr !== 6'b000110 || g_ghr !== 6'b000110) begin
      misses++; $display("FAIL recover_priority: got b=%b g=%b expected 000110", b_ghr, g_ghr);
    end
    set_upd1(9'h012, 1, 9'h040, 6'b000001, 1);
    set_upd2(9'h013, 0, 9'h000, 6'b111111, 1);
    @(negedge clk);
    clear_inputs();
    #2;
    vectors++;
    if (b_ghr !== 6'b000011 || g_ghr !== 6'b000011) begin
      misses++; $display("FAIL recover_both: got b=%b g=%b expected 000011", b_ghr, g_ghr);
    end
    vectors++;
    if (g_cnt !== 16'd4 || b_cnt !== 2'd3) begin
      misses++; $display("FAIL recover_count: got g=%0d b=%0d expected g=4 b=3", g_cnt, b_cnt);
    end
  endtask

  task automatic test_saturation;
    apply_reset();
    set_upd1(9'h005, 1, 9'h020, 6'd0, 0);
    @(negedge clk);
    @(negedge clk);
    for (int k = 1; k <= 4; k++) begin
      clear_inputs();
      set_upd1(9'h010, 0, 9'h000, 6'd0, 1);
      @(negedge clk);
      clear_inputs();
      #2;
      vectors++;
      if (int'(b_cnt) != ((k > 3) ? 3 : k) || int'(g_cnt) != k) begin
        misses++; $display("FAIL sat_count%0d: got b=%0d g=%0d expected b=%0d g=%0d", k, b_cnt, g_cnt, (k > 3) ? 3 : k, k);
      end
    end
    fetch_pc = 9'h005;
    #1;
    reset = 0;
    model_reset();
    #1;
    vectors++;
    if (b_cnt !== 2'd0 || g_cnt !== 16'd0 || b_pred_taken !== 1'b0 || b_pred_target !== 9'h006) begin
      misses++; $display("FAIL mid_reset: got b_cnt=%0d g_cnt=%0d taken=%0b target=%h expected 0 0 0 006",
                         b_cnt, g_cnt, b_pred_taken, b_pred_target);
    end
    @(negedge clk);
    reset = 1;
    // Load history 000001, then fetch the formerly trained pc: a miss leaves history alone.
    set_upd1(9'h01f, 1, 9'h011, 6'd0, 1);
    @(negedge clk);
    clear_inputs();
    fetch_valid = 1; fetch_pc = 9'h005;
    @(negedge clk);
    clear_inputs();
    #2;
    vectors++;
    if (b_ghr !== 6'd1 || g_ghr !== 6'd1) begin
      misses++; $display("FAIL btb_cleared: got b=%b g=%b expected 000001", b_ghr, g_ghr);
    end
  endtask

  function automatic logic [8:0] rand_pc();
    case ($urandom_range(0, 3))
      0:       return 9'h005;
      1:       return 9'h045;
      2:       return 9'($urandom_range(0, 15));
      default: return 9'($urandom_range(0, 511));
    endcase
  endfunction

  task automatic test_random;
    apply_reset();
    repeat (600) begin
      @(negedge clk);
      fetch_valid = ($urandom_range(0, 1) == 1);
      fetch_pc = rand_pc();
      upd1_valid = ($urandom_range(0, 1) == 1);
      upd1_pc = rand_pc();
      upd1_taken = ($urandom_range(0, 1) == 1);
      upd1_target = 9'($urandom_range(0, 511));
      upd1_ghr = 6'($urandom_range(0, 63));
      upd1_mispredict = ($urandom_range(0, 3) == 0);
      upd2_valid = ($urandom_range(0, 1) == 1);
      upd2_pc = ($urandom_range(0, 3) == 0) ? upd1_pc : rand_pc();
      upd2_taken = ($urandom_range(0, 1) == 1);
      upd2_target = 9'($urandom_range(0, 511));
      upd2_ghr = ($urandom_range(0, 1) == 1) ? upd1_ghr : 6'($urandom_range(0, 63));
      upd2_mispredict = ($urandom_range(0, 3) == 0);
      #2;
      for (int m = 0; m < 2; m++) begin
        vectors++;
        if (dut_vec(m) !== exp_vec(m)) begin
          misses++; $display("FAIL random inst%0d pc=%h: got %h expected %h", m, fetch_pc, dut_vec(m), exp_vec(m));
        end
      end
    end
    @(negedge clk);
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    reset = 0;
    model_reset();
    test_reset();
    test_train_hit();
    test_alias();
    test_dual_same_index();
    test_recovery();
    test_saturation();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
    $finish;
  end

endmodule

// File: doc/bpu_gshare_dual.md
Name: bpu_gshare_dual

Overview:
- Parametrised dual-update branch predictor for the superscalar fetch stage.
- Generalises the fixed 64-entry bimodal BHT/BTB in four ways:
  - configurable PC, index and history widths;
  - selectable bimodal or gshare indexing;
  - tagged BTB;
  - speculative global history with checkpoint/restore on mispredict.
- Also carries a saturating mispredict counter.
- One lookup port serves fetch. Two resolve ports (slot 1 = older, slot 2 = younger) come from the Memory stage.

Parameters:
- PC_W, 9, program-counter width (word addresses).
- IDX_W, 6, table index width; BHT/BTB depth = 2**IDX_W.
- GHR_W, 6, global history length; must be <= IDX_W.
- TAG_W, 3, BTB tag width; tag = pc[IDX_W+TAG_W-1:IDX_W]; IDX_W+TAG_W <= PC_W.
- GSHARE, 1, 1 = index pc[IDX_W-1:0] XOR zero-extended history; 0 = pure pc index.
- CNT_W, 16, mispredict counter width.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-low reset
- fetch_valid  in  1  lookup request this cycle
- fetch_pc  in  PC_W  PC being fetched
- pred_taken  out  1  predicted taken
- pred_target  out  PC_W  predicted next PC
- pred_ghr  out  GHR_W  history snapshot used for this lookup (travels with instruction)
- updN_valid  in  1  (N=1,2) resolved branch in slot N
- updN_pc  in  PC_W  branch PC
- updN_taken  in  1  actual outcome
- updN_target  in  PC_W  actual taken target
- updN_ghr  in  GHR_W  pred_ghr captured at fetch for this branch
- updN_mispredict  in  1  outcome or target differed from prediction
- ghr  out  GHR_W  current speculative history
- mispredict_count  out  CNT_W  saturating count of resolved mispredicts

Behaviour:
Reset (reset low, async):
- All BHT counters = 2'b01.
- All BTB valid = 0, targets = 0, tags = 0.
- ghr = 0, mispredict_count = 0.
- The combinational outputs follow from this state: pred_taken = 0, pred_target = fetch_pc+1.

Lookup (combinational, 0-cycle latency, from registered state):
- bidx = GSHARE ? (pc[IDX_W-1:0] ^ ghr) : pc[IDX_W-1:0].
- BTB is always pc-indexed.
- hit = btb_valid[pc idx] && btb_tag == pc tag.
- pred_taken = hit & bht[bidx][1].
- pred_target = pred_taken ? btb_target : fetch_pc+1, with the +1 wrapping modulo 2**PC_W.
- pred_ghr = ghr.
- Outputs are valid regardless of fetch_valid.

Speculative history:
- On a clock edge with fetch_valid && hit: ghr <= {ghr[GHR_W-2:0], pred_taken}.
- No shift on a BTB miss (not treated as a branch).

Resolve (registered, 1-cycle):
- Slot N recomputes its index from updN_pc and updN_ghr, never from the live ghr.
- 2-bit saturating update: taken increments to max 11; not-taken decrements to min 00.
- On updN_taken, write BTB entry: target, tag, valid=1.
- A not-taken branch never allocates a BTB entry and never clears one.

Same-cycle collisions:
- Both slots hit the same BHT index: apply slot 1 then slot 2 sequentially, i.e. net change, e.g. 01 +T +T -> 11, 10 +T -N -> 10.
- Both slots write the same BTB entry: slot 2 data wins.

Recovery:
- If any updN_valid && updN_mispredict, then ghr <= {updN_ghr[GHR_W-2:0], updN_taken}.
- If both slots mispredict, slot 1 (older) wins.
- Recovery has priority over a same-cycle speculative shift; the fetch shift is discarded.

mispredict_count:
- Adds (upd1_valid&upd1_mispredict) + (upd2_valid&upd2_mispredict) per cycle, range 0..2.
- Saturates at 2**CNT_W-1; never wraps.

Other rules:
- updN_mispredict with updN_valid=0 is ignored.
- Reset asserted mid-operation clears all state immediately; the first post-reset lookup sees reset values.

Decomposition:
- Package bpu_pkg holds:
  - typedef ctr2_t (2-bit counter);
  - constants CTR_SNT=00, CTR_WNT=01, CTR_WT=10, CTR_ST=11;
  - function sat_ctr_next(ctr, taken).
- One sub-module, bpu_btb: tagged BTB storage with one combinational read port, two write ports and slot-2 write priority.
- BHT, GHR and counter logic stay in the top level.

Test Plan:
1. Reset then lookup pc=0x005 -> pred_taken=0, pred_target=0x006, ghr=0, mispredict_count=0.
2. GSHARE=0. Resolve pc=0x005, taken, target=0x020 on two consecutive cycles. Then lookup 0x005 -> hit, counter 11, pred_taken=1, pred_target=0x020.
3. Tag alias, IDX_W=6: train pc=0x005 taken to 0x020. Lookup pc=0x045 (same index, tag differs) -> pred_taken=0, pred_target=0x046.
4. Dual same-index update. Both slots pc=0x005, counter 01, upd1 taken, upd2 taken -> counter 11. Same cycle with targets 0x020/0x030 -> BTB target 0x030.
5. History recovery. ghr=6'b101101, fetch hit with pred_taken=1, same cycle upd1 mispredict with upd1_ghr=6'b000011, taken=0 -> next ghr=6'b000110, not 6'b011011. Both slots mispredicting -> slot 1 history used and count +2.
6. CNT_W=2: drive 4 single mispredicts -> count 1,2,3,3 (saturated). Assert reset mid-sequence -> count=0 and all BTB entries miss.
